// File: rtl/timer_scheduler.sv
// timer_scheduler
// Shares one delay timer between two requesters (player and dealer).
// A granted requester owns the timer for DELAY_TICKS ticks of TICK_DIV
// clock cycles each, then receives a one-cycle done pulse. Simultaneous
// requests are arbitrated round-robin, player first after reset.
// Every output is taken straight from a register.

module timer_scheduler #(
    parameter int TICK_DIV    = 25000,
    parameter int COUNT_WIDTH = 12,
    parameter int DELAY_TICKS = 4095
) (
    input  logic                   clk_50M,
    input  logic                   i_Reset,
    input  logic                   i_ReqPlayer,
    input  logic                   i_ReqDealer,
    input  logic                   i_Abort,
    output logic                   o_GntPlayer,
    output logic                   o_GntDealer,
    output logic                   o_DonePlayer,
    output logic                   o_DoneDealer,
    output logic                   o_Busy,
    output logic                   o_Tick,
    output logic [COUNT_WIDTH-1:0] o_Count
);

    // Requester indices used in the two-bit vectors below.
    localparam int PLAYER = 0;
    localparam int DEALER = 1;
    localparam int NUM_REQ = 2;

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]     PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DELAY_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_reg,       state_next;
    logic [PRESC_W-1:0]       presc_reg,       presc_next;
    logic [COUNT_WIDTH-1:0]   count_reg,       count_next;
    logic [NUM_REQ-1:0]       gnt_reg,         gnt_next;
    logic [NUM_REQ-1:0]       done_reg,        done_next;
    logic                     busy_reg,        busy_next;
    logic                     tick_reg,        tick_next;
    // 1 when the dealer was the last requester served to completion;
    // this is also the reset value so the player has priority first.
    logic                     last_dealer_reg, last_dealer_next;

    logic [NUM_REQ-1:0]       req_vec;
    logic [NUM_REQ-1:0]       owner_req;
    logic                     owner_active;
    logic                     pick_dealer;
    logic [COUNT_WIDTH-1:0]   count_inc;

    assign req_vec[PLAYER] = i_ReqPlayer;
    assign req_vec[DEALER] = i_ReqDealer;

    // Per requester: is it the timer owner and still holding its request?
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_owner
            assign owner_req[gi] = gnt_reg[gi] & req_vec[gi];
        end
    endgenerate

    assign owner_active = |owner_req;
    assign count_inc    = count_reg + COUNT_WIDTH'(1);

    // The dealer wins only if it alone requests, or if both request and
    // the player was served last.
    assign pick_dealer  = req_vec[DEALER] & (~req_vec[PLAYER] | ~last_dealer_reg);

    // State register and all registered outputs.
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_reg       <= ST_IDLE;
            presc_reg       <= '0;
            count_reg       <= '0;
            gnt_reg         <= '0;
            done_reg        <= '0;
            busy_reg        <= 1'b0;
            tick_reg        <= 1'b0;
            last_dealer_reg <= 1'b1;
        end else begin
            state_reg       <= state_next;
            presc_reg       <= presc_next;
            count_reg       <= count_next;
            gnt_reg         <= gnt_next;
            done_reg        <= done_next;
            busy_reg        <= busy_next;
            tick_reg        <= tick_next;
            last_dealer_reg <= last_dealer_next;
        end
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_next       = state_reg;
        presc_next       = presc_reg;
        count_next       = count_reg;
        gnt_next         = gnt_reg;
        done_next        = '0;
        tick_next        = 1'b0;
        last_dealer_next = last_dealer_reg;

        case (state_reg)
            ST_IDLE: begin
                // Abort has no meaning here; only requests matter.
                if (|req_vec) begin
                    state_next         = ST_RUN;
                    presc_next         = '0;
                    count_next         = '0;
                    gnt_next           = '0;
                    gnt_next[DEALER]   = pick_dealer;
                    gnt_next[PLAYER]   = ~pick_dealer;
                end
            end

            ST_RUN: begin
                if (i_Abort || !owner_active) begin
                    // Cancellation beats a coinciding final tick: no done,
                    // no pointer update, elapsed count discarded.
                    state_next = ST_IDLE;
                    presc_next = '0;
                    count_next = '0;
                    gnt_next   = '0;
                end else if (presc_reg == PRESC_LAST) begin
                    presc_next = '0;
                    tick_next  = 1'b1;
                    count_next = count_inc;
                    if (count_inc == COUNT_LAST) begin
                        // Grant is released and done raised together so
                        // the owner sees exactly one cycle of done.
                        state_next       = ST_DONE;
                        done_next        = gnt_reg;
                        gnt_next         = '0;
                        last_dealer_next = gnt_reg[DEALER];
                    end
                end else begin
                    presc_next = presc_reg + PRESC_W'(1);
                end
            end

            ST_DONE: begin
                // Inputs are ignored; a request still high is picked up
                // as a fresh request once back in IDLE.
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                presc_next = '0;
                count_next = '0;
                gnt_next   = '0;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    assign o_GntPlayer  = gnt_reg[PLAYER];
    assign o_GntDealer  = gnt_reg[DEALER];
    assign o_DonePlayer = done_reg[PLAYER];
    assign o_DoneDealer = done_reg[DEALER];
    assign o_Busy       = busy_reg;
    assign o_Tick       = tick_reg;
    assign o_Count      = count_reg;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with TICK_DIV=4, DELAY_TICKS=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_timer_scheduler;

    localparam int TD = 4;
    localparam int DT = 3;
    localparam int CW = 4;
    localparam int LAST_K = TD * DT; // edge index of the done pulse

    logic          clk_50M = 1'b0;
    logic          i_Reset;
    logic          i_ReqPlayer;
    logic          i_ReqDealer;
    logic          i_Abort;
    logic          o_GntPlayer;
    logic          o_GntDealer;
    logic          o_DonePlayer;
    logic          o_DoneDealer;
    logic          o_Busy;
    logic          o_Tick;
    logic [CW-1:0] o_Count;

    int compared   = 0;
    int mismatched = 0;

    timer_scheduler #(
        .TICK_DIV   (TD),
        .COUNT_WIDTH(CW),
        .DELAY_TICKS(DT)
    ) dut (
        .clk_50M     (clk_50M),
        .i_Reset     (i_Reset),
        .i_ReqPlayer (i_ReqPlayer),
        .i_ReqDealer (i_ReqDealer),
        .i_Abort     (i_Abort),
        .o_GntPlayer (o_GntPlayer),
        .o_GntDealer (o_GntDealer),
        .o_DonePlayer(o_DonePlayer),
        .o_DoneDealer(o_DoneDealer),
        .o_Busy      (o_Busy),
        .o_Tick      (o_Tick),
        .o_Count     (o_Count)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check every output against explicit expected values.
    task automatic chk_all(input string tag, input logic gp, input logic gd, input logic dp,
                           input logic dd, input logic busy, input logic tick, input int cnt);
        chk({tag, ".gnt_p"},  32'(o_GntPlayer),  32'(gp));
        chk({tag, ".gnt_d"},  32'(o_GntDealer),  32'(gd));
        chk({tag, ".done_p"}, 32'(o_DonePlayer), 32'(dp));
        chk({tag, ".done_d"}, 32'(o_DoneDealer), 32'(dd));
        chk({tag, ".busy"},   32'(o_Busy),       32'(busy));
        chk({tag, ".tick"},   32'(o_Tick),       32'(tick));
        chk({tag, ".count"},  32'(o_Count),      32'(cnt));
    endtask

    // Advance through delay edges k = from_k..to_k (edge 0 = grant edge)
    // and check the expected tick/count/grant/done pattern at each one.
    task automatic run_steps(input string tag, input bit dealer, input int from_k, input int to_k);
        for (int k = from_k; k <= to_k; k++) begin
            logic own_gnt;
            logic own_done;
            logic tk;
            step();
            own_gnt  = (k < LAST_K);
            own_done = (k == LAST_K);
            tk       = ((k % TD) == 0);
            chk_all($sformatf("%s.k%0d", tag, k),
                    dealer ? 1'b0 : own_gnt, dealer ? own_gnt : 1'b0,
                    dealer ? 1'b0 : own_done, dealer ? own_done : 1'b0,
                    1'b1, tk, k / TD);
            $display("[%0t] %s edge %0d: gntP=%0b gntD=%0b doneP=%0b doneD=%0b tick=%0b count=%0d",
                     $time, tag, k, o_GntPlayer, o_GntDealer, o_DonePlayer, o_DoneDealer, o_Tick, o_Count);
        end
    endtask

    initial begin
        i_Reset     = 1'b1;
        i_ReqPlayer = 1'b0;
        i_ReqDealer = 1'b0;
        i_Abort     = 1'b0;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        i_Reset = 1'b0;
        step();
        chk_all("idle_no_req", 0, 0, 0, 0, 0, 0, 0);

        // Player-only delay, full length; abort in IDLE must be ignored.
        i_Abort     = 1'b1;
        step();
        chk_all("idle_abort", 0, 0, 0, 0, 0, 0, 0);
        i_Abort     = 1'b0;
        i_ReqPlayer = 1'b1;
        step();
        chk_all("p_only.k0", 1, 0, 0, 0, 1, 0, 0);
        run_steps("p_only", 1'b0, 1, LAST_K);
        i_ReqPlayer = 1'b0;
        step();
        chk_all("p_only.idle", 0, 0, 0, 0, 0, 0, DT);
        step();
        chk_all("p_only.hold", 0, 0, 0, 0, 0, 0, DT);

        // Player was served last. Dealer delay, then reset at count=2
        // with both requests pending: player must win after reset.
        i_ReqDealer = 1'b1;
        step();
        chk_all("d_rst.k0", 0, 1, 0, 0, 1, 0, 0);
        run_steps("d_rst", 1'b1, 1, 2 * TD);
        i_ReqPlayer = 1'b1;
        i_Reset     = 1'b1;
        step();
        chk_all("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        i_Reset = 1'b0;
        step();
        chk_all("rr1.k0", 1, 0, 0, 0, 1, 0, 0);

        // Both held: player, dealer, player.
        run_steps("rr1", 1'b0, 1, LAST_K);
        step();
        chk_all("rr1.idle", 0, 0, 0, 0, 0, 0, DT);
        step();
        chk_all("rr2.k0", 0, 1, 0, 0, 1, 0, 0);
        run_steps("rr2", 1'b1, 1, LAST_K);
        step();
        chk_all("rr2.idle", 0, 0, 0, 0, 0, 0, DT);
        step();
        chk_all("rr3.k0", 1, 0, 0, 0, 1, 0, 0);

        // Player withdraws exactly as the final tick lands: no done.
        i_ReqDealer = 1'b0;
        run_steps("wd", 1'b0, 1, LAST_K - 1);
        i_ReqPlayer = 1'b0;
        step();
        chk_all("withdraw", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_all("withdraw.idle", 0, 0, 0, 0, 0, 0, 0);

        // Dealer delay aborted at edge 6 while the player waits.
        i_ReqDealer = 1'b1;
        step();
        chk_all("ab.k0", 0, 1, 0, 0, 1, 0, 0);
        i_ReqPlayer = 1'b1;
        run_steps("ab", 1'b1, 1, 5);
        i_Abort = 1'b1;
        step();
        chk_all("abort", 0, 0, 0, 0, 0, 0, 0);
        i_Abort     = 1'b0;
        i_ReqDealer = 1'b0;
        step();
        chk_all("after_abort.k0", 1, 0, 0, 0, 1, 0, 0);
        run_steps("after_abort", 1'b0, 1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute bound in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 25000: clk_50M cycles per delay tick (2 kHz at 50 MHz); legal range >= 2.
REQ-002 Parameter COUNT_WIDTH, default 12: width of o_Count.
REQ-003 Parameter DELAY_TICKS, default 4095: ticks per granted delay (about 2 s); legal range 1 .. 2**COUNT_WIDTH-1.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk_50M  in  1  sole clock, all logic on its rising edge.
- i_Reset  in  1  synchronous active-high reset.
- i_ReqPlayer  in  1  player delay request; level, held until done or withdrawn.
- i_ReqDealer  in  1  dealer delay request; level, held until done or withdrawn.
- i_Abort  in  1  cancels the active delay.
- o_GntPlayer  out  1  player owns the timer.
- o_GntDealer  out  1  dealer owns the timer.
- o_DonePlayer  out  1  one-cycle pulse: player delay complete.
- o_DoneDealer  out  1  one-cycle pulse: dealer delay complete.
- o_Busy  out  1  high in RUN and DONE.
- o_Tick  out  1  one-cycle delay-tick strobe, RUN only.
- o_Count  out  COUNT_WIDTH  elapsed ticks of current/last delay.

Function
REQ-005 The FSM SHALL have states IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-006 In IDLE with at least one request high, the block SHALL issue exactly one grant at the next edge and go to RUN; at that same edge prescaler and o_Count SHALL clear to 0.
REQ-007 With both requests high in IDLE, arbitration SHALL be round-robin: the requester not served last wins, and after reset the player wins.
REQ-008 In RUN, the prescaler SHALL increment every cycle and wrap at TICK_DIV-1; o_Tick SHALL be high for the cycle following each wrap, and o_Count SHALL increment by 1 at the same edge.
REQ-009 When o_Count reaches DELAY_TICKS, the next state SHALL be DONE; RUN therefore lasts exactly DELAY_TICKS*TICK_DIV cycles.
REQ-010 In DONE, for exactly one cycle:
- the granted requester's done output SHALL be high;
- its grant SHALL drop;
- the round-robin pointer SHALL update;
- the next state SHALL be IDLE.
REQ-011 o_Count SHALL hold its value through DONE and IDLE until the next grant; it SHALL never exceed DELAY_TICKS and never wrap.
REQ-012 Requesters SHALL deassert their request on the cycle they sample done high; a request still high in IDLE SHALL be treated as a new request.
REQ-013 If i_Abort is high in RUN, or the granted request drops in RUN, the next state SHALL be IDLE:
- grant cleared and o_Count cleared;
- no done pulse;
- pointer not updated.
REQ-014 If an abort or withdrawal occurs in the same cycle as the final tick, the abort/withdrawal SHALL win and no done pulse is issued.
REQ-015 Requests and i_Abort SHALL be ignored in DONE; i_Abort SHALL be ignored in IDLE.
REQ-016 A request from the non-granted requester during RUN SHALL be held pending and served after DONE returns to IDLE.

Reset
REQ-017 When i_Reset is high at an edge:
- state SHALL go to IDLE;
- prescaler, o_Count, all grants, dones, o_Busy and o_Tick SHALL go to 0;
- the round-robin pointer SHALL select player priority.
REQ-018 Reset SHALL override every other input, including mid-RUN and in DONE, with no done pulse emitted.

Verification (TICK_DIV=4, DELAY_TICKS=3, COUNT_WIDTH=4)
REQ-019 Player-only request: i_ReqPlayer high at edge 0 -> o_GntPlayer high from edge 0; o_Tick at cycles 4, 8, 12; o_Count=3; o_DonePlayer pulse at edge 12; o_Busy low after edge 13.
REQ-020 Both requests held, served twice: player granted first, dealer second, player third; exactly one grant high at any time.
REQ-021 i_Abort pulsed at cycle 6 of a dealer delay -> IDLE at next edge; o_Count=0; no o_DoneDealer; a waiting player request is granted next.
REQ-022 i_ReqPlayer dropped in the same cycle as the third tick -> no o_DonePlayer; o_GntPlayer low next edge; o_Count=0.
REQ-023 i_Reset asserted mid-RUN with o_Count=2 -> all outputs 0 at next edge; a subsequent simultaneous request grants the player.
